mcu_led_fx: RTL and testbench

//   LED effect driver placed directly downstream of the 1-bit LED PIO output port.

---
 rtl/mcu_led_fx_pkg.sv | 33 +++
 rtl/mcu_led_fx_if.sv | 32 +++
 rtl/mcu_led_fx_tick.sv | 31 +++
 rtl/mcu_led_fx.sv | 168 ++++++++++++++++
 tb/tb_mcu_led_fx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_led_fx_pkg.sv
// mcu_led_pkg: shared constants and types for the LED effect driver.
//   mode_t       : CTRL[1:0] effect mode encoding
//   addr_t       : Avalon-MM word addresses of the register map
//   breath_dir_t : ramp direction of the breathing effect
//   blink_last() : terminal blink count for a given PERIOD (PERIOD 0 acts as 1)
package mcu_led_pkg;

    localparam int unsigned PWM_W = 8;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_STEADY  = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ADDR_CTRL   = 2'd0,
        ADDR_PERIOD = 2'd1,
        ADDR_DUTY   = 2'd2,
        ADDR_STATUS = 2'd3
    } addr_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } breath_dir_t;

    function automatic logic [15:0] blink_last(input logic [15:0] period);
        return (period == 16'd0) ? 16'd0 : period - 16'd1;
    endfunction

endpackage

// File: rtl/mcu_led_fx_if.sv
// mcu_led_fx_if: Avalon-MM configuration port of the LED effect driver.
//   address[1:0]    word address
//   chipselect      slave select
//   write_n         write strobe, active low
//   writedata[31:0] write data
//   readdata[31:0]  combinational read data, zero wait states
// Modports: slave (the driver), master (the bus side).
interface mcu_led_fx_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

endinterface

// File: rtl/mcu_led_fx_tick.sv
// mcu_led_tick: free-running prescaler producing the effect time base.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   tick     out 1-clk pulse while the counter sits at PRESCALE-1
// Parameter PRESCALE (>=2): clk cycles per tick.
module mcu_led_tick #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mcu_led_fx.sv
// mcu_led_fx: LED effect driver sitting behind the 1-bit LED PIO output.
// Adds PWM brightness, blink and optional breathing, configured over Avalon-MM.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   led_en   in  enable bit from the upstream LED PIO
//   bus      slave modport of mcu_led_fx_if (address/chipselect/write_n/writedata/readdata)
//   led_out  out registered LED pin drive
// Registers: 0 CTRL[1:0], 1 PERIOD[15:0], 2 DUTY[7:0], 3 STATUS {blink_phase, led_on, led_en}.
// Optional feature: define MCU_LED_FX_BREATHE_EN to build the breathing ramp for mode 3;
// without it mode 3 drives the LED exactly like STEADY.
module mcu_led_fx
    import mcu_led_pkg::*;
#(
    parameter int unsigned PRESCALE       = 50000,
    parameter int unsigned DEFAULT_PERIOD = 500,
    parameter bit          ACTIVE_LOW     = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         led_en,
    mcu_led_fx_if.slave  bus,
    output logic         led_out
);

    mode_t             mode;
    logic [15:0]       period;
    logic [PWM_W-1:0]  duty;
    logic [PWM_W-1:0]  duty_eff;
    logic [PWM_W-1:0]  pwm_cnt;
    logic [15:0]       blink_cnt;
    logic              blink_phase;
    logic              pwm_on;
    logic              led_on;
    logic              tick;
    logic              wr;
    addr_t             addr;
    logic [31:0]       rdata;
    logic              unused_wdata;

    assign addr         = addr_t'(bus.address);
    assign wr           = bus.chipselect & ~bus.write_n;
    assign unused_wdata = ^bus.writedata[31:16];

    mcu_led_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Configuration registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode   <= MODE_STEADY;
            period <= 16'(DEFAULT_PERIOD);
            duty   <= '1;
        end else if (wr) begin
            case (addr)
                ADDR_CTRL:   mode   <= mode_t'(bus.writedata[1:0]);
                ADDR_PERIOD: period <= bus.writedata[15:0];
                ADDR_DUTY:   duty   <= bus.writedata[PWM_W-1:0];
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end

    // A PERIOD write restarts the blink cycle in the "on" half and takes
    // priority over a terminal count landing in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (wr && addr == ADDR_PERIOD) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (tick) begin
            if (blink_cnt == blink_last(period)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

`ifdef MCU_LED_FX_BREATHE_EN
    breath_dir_t       breath_dir;
    breath_dir_t       breath_dir_nxt;
    logic [PWM_W-1:0]  breath_duty;
    logic [PWM_W-1:0]  breath_duty_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            breath_dir  <= DIR_UP;
            breath_duty <= '0;
        end else begin
            breath_dir  <= breath_dir_nxt;
            breath_duty <= breath_duty_nxt;
        end
    end

    // At either end value the tick only flips direction, so 255 and 0 are held one tick.
    always_comb begin
        breath_dir_nxt  = breath_dir;
        breath_duty_nxt = breath_duty;
        if (mode != MODE_BREATHE) begin
            breath_dir_nxt  = DIR_UP;
            breath_duty_nxt = '0;
        end else if (tick) begin
            unique case (breath_dir)
                DIR_UP: begin
                    if (breath_duty == '1) breath_dir_nxt  = DIR_DOWN;
                    else                   breath_duty_nxt = breath_duty + PWM_W'(1);
                end
                DIR_DOWN: begin
                    if (breath_duty == '0) breath_dir_nxt  = DIR_UP;
                    else                   breath_duty_nxt = breath_duty - PWM_W'(1);
                end
            endcase
        end
    end

    assign duty_eff = (mode == MODE_BREATHE) ? breath_duty : duty;
`else
    assign duty_eff = duty;
`endif

    assign pwm_on = (duty_eff == '1) | (pwm_cnt < duty_eff);

    // BREATHE gates like STEADY; the breathing itself comes in through duty_eff.
    always_comb begin
        led_on = 1'b0;
        unique case (mode)
            MODE_OFF:     led_on = 1'b0;
            MODE_STEADY:  led_on = pwm_on;
            MODE_BLINK:   led_on = pwm_on & blink_phase;
            MODE_BREATHE: led_on = pwm_on;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= ACTIVE_LOW;
        end else begin
            led_out <= (led_en & led_on) ^ ACTIVE_LOW;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (addr)
            ADDR_CTRL:   rdata[1:0]       = mode;
            ADDR_PERIOD: rdata[15:0]      = period;
            ADDR_DUTY:   rdata[PWM_W-1:0] = duty;
            ADDR_STATUS: rdata[2:0]       = {blink_phase, led_on, led_en};
        endcase
    end

    assign bus.readdata = rdata;

endmodule

// File: tb/tb_mcu_led_fx.sv
// tb_mcu_led_fx: directed self-checking bench for mcu_led_fx (PRESCALE=4),
// plus an ACTIVE_LOW=1 instance for output polarity.
module tb_mcu_led_fx;
    import mcu_led_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic led_en;
    logic led_out;
    logic led_out_al;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mcu_led_fx_if bus ();
    mcu_led_fx_if bus_al ();

    mcu_led_fx #(.PRESCALE(4), .DEFAULT_PERIOD(500), .ACTIVE_LOW(1'b0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .led_en  (led_en),
        .bus     (bus.slave),
        .led_out (led_out)
    );

    mcu_led_fx #(.PRESCALE(4), .DEFAULT_PERIOD(500), .ACTIVE_LOW(1'b1)) dut_al (
        .clk     (clk),
        .reset_n (reset_n),
        .led_en  (led_en),
        .bus     (bus_al.slave),
        .led_out (led_out_al)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write is taken at the following posedge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd3;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        #1 d = bus.readdata;
    endtask

    task automatic count_high(input int ncyc, output int hi);
        hi = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (led_out === 1'b1) hi++;
        end
    endtask

    // Called right after a PERIOD write; returns the spacing of the 2nd/3rd
    // phase toggles and how often led_out failed to follow the phase by one clk.
    task automatic measure(input int ncyc, output int d1, output int d2, output int lagerr);
        int   t [3];
        int   ntr;
        logic prev_ph;
        logic ph;
        t      = '{default: 0};
        ntr    = 0;
        lagerr = 0;
        #1 prev_ph = bus.readdata[2];
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            ph = bus.readdata[2];
            if (led_out !== prev_ph) lagerr++;
            if (ph !== prev_ph && ntr < 3) begin
                t[ntr] = n;
                ntr++;
            end
            prev_ph = ph;
        end
        d1 = t[1] - t[0];
        d2 = t[2] - t[1];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          hi;
        int          d1;
        int          d2;
        int          lag;
        int          ones;
        logic        prev_ph;
        bit          found;

        reset_n           = 1'b0;
        led_en            = 1'b0;
        bus.address       = 2'd3;
        bus.chipselect    = 1'b0;
        bus.write_n       = 1'b1;
        bus.writedata     = '0;
        bus_al.address    = 2'd3;
        bus_al.chipselect = 1'b0;
        bus_al.write_n    = 1'b1;
        bus_al.writedata  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_led_out", led_out, 0);
        check("rst_led_out_al", led_out_al, 1);
        bus_read(ADDR_CTRL, rd);   check("rst_ctrl", rd, 1);
        bus_read(ADDR_PERIOD, rd); check("rst_period", rd, 500);
        bus_read(ADDR_DUTY, rd);   check("rst_duty", rd, 32'hFF);
        bus_read(ADDR_STATUS, rd); check("rst_status", rd, 32'h6);

        // led_en -> led_out one clk later
        @(negedge clk);
        led_en = 1'b1;
        #1 check("en_same_cycle", led_out, 0);
        @(negedge clk);
        check("en_lat1", led_out, 1);
        check("en_lat1_al", led_out_al, 0);

        // PWM duty in STEADY
        bus_write(ADDR_DUTY, 64);
        count_high(1024, hi); check("pwm_duty64", hi, 256);
        bus_write(ADDR_DUTY, 0);
        count_high(256, hi);  check("pwm_duty0", hi, 0);
        bus_write(ADDR_DUTY, 1);
        count_high(256, hi);  check("pwm_duty1", hi, 1);
        bus_write(ADDR_DUTY, 255);
        count_high(256, hi);  check("pwm_duty255", hi, 256);
        bus_write(ADDR_CTRL, 0);
        count_high(64, hi);   check("mode_off", hi, 0);

        // Blink: PRESCALE 4 x PERIOD 3 = 12 clk per half period
        bus_write(ADDR_CTRL, 2);
        bus_write(ADDR_PERIOD, 3);
        measure(60, d1, d2, lag);
        check("blink_p3_gap1", d1, 12);
        check("blink_p3_gap2", d2, 12);
        check("blink_p3_status_lag", lag, 0);

        bus_write(ADDR_PERIOD, 0);
        measure(30, d1, d2, lag);
        check("blink_p0_gap1", d1, 4);
        check("blink_p0_gap2", d2, 4);
        check("blink_p0_status_lag", lag, 0);

        // PERIOD write on the terminal-count cycle
        bus_write(ADDR_PERIOD, 3);
        #1 prev_ph = bus.readdata[2];
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (prev_ph === 1'b0 && bus.readdata[2] === 1'b1) found = 1'b1;
            prev_ph = bus.readdata[2];
        end
        check("coll_found_toggle", found, 1);
        repeat (11) @(negedge clk);
        bus_write(ADDR_PERIOD, 3);
        #1 check("coll_phase_kept", bus.readdata[2], 1);
        ones = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (bus.readdata[2] === 1'b1) ones++;
        end
        check("coll_hold", ones, 11);
        @(negedge clk);
        check("coll_next_toggle", bus.readdata[2], 0);

        // Gating by led_en during BLINK
        bus_write(ADDR_PERIOD, 77);
        @(negedge clk);
        check("gate_pre", led_out, 1);
        led_en = 1'b0;
        @(negedge clk);
        check("gate_off", led_out, 0);
        led_en = 1'b1;
        @(negedge clk);
        check("gate_on", led_out, 1);

        // Asynchronous reset mid-blink, with non-default registers
        bus_write(ADDR_DUTY, 32'h40);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (led_out === 1'b1) found = 1'b1;
        end
        check("prereset_led_high", found, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_led", led_out, 0);
        check("async_rst_led_al", led_out_al, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(ADDR_CTRL, rd);   check("rerst_ctrl", rd, 1);
        bus_read(ADDR_PERIOD, rd); check("rerst_period", rd, 500);
        bus_read(ADDR_DUTY, rd);   check("rerst_duty", rd, 32'hFF);
        bus_read(ADDR_STATUS, rd); check("rerst_status", rd, 32'h7);

        // Mode 3
        @(negedge clk);
`ifdef MCU_LED_FX_BREATHE_EN
        bus_write(ADDR_CTRL, 3);
        hi = 0;
        for (int i = 0; i < 2000 && hi < 255; i++) begin
            if (dut.tick === 1'b1) hi++;
            if (hi < 255) @(negedge clk);
        end
        @(negedge clk);
        check("breathe_top", dut.breath_duty, 255);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (dut.tick === 1'b1) found = 1'b1;
            @(negedge clk);
        end
        check("breathe_hold", dut.breath_duty, 255);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (dut.tick === 1'b1) found = 1'b1;
            @(negedge clk);
        end
        check("breathe_down", dut.breath_duty, 254);
`else
        bus_write(ADDR_DUTY, 64);
        bus_write(ADDR_CTRL, 3);
        bus_read(ADDR_CTRL, rd); check("mode3_ctrl_read", rd, 3);
        @(negedge clk);
        count_high(256, hi); check("mode3_as_steady", hi, 64);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
